// File: rtl/shift_pkg.sv
// Shared constants and op encodings for the shift arbiter and its shift core.
package shift_pkg;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two requesters, the shift arbiter and the result consumer.
interface shift_arbiter_if;
    import shift_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [SHW-1:0]   req0_shamt;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [SHW-1:0]   req1_shamt;
    logic [1:0]       req1_op;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             last_grant;

    // Handshake: a transfer happens on a rising clk edge where valid && ready; the sender
    // holds its payload stable while valid && !ready, and ready never depends on a future valid.
    modport master (
        output req_valid, req0_a, req0_shamt, req0_op, req1_a, req1_shamt, req1_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, last_grant
    );

    modport slave (
        input  req_valid, req0_a, req0_shamt, req0_op, req1_a, req1_shamt, req1_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, last_grant
    );
endinterface

// File: rtl/shift_core.sv
// Combinational 32-bit barrel shifter: five log stages (1/2/4/8/16).
// Op 11 rotates right when SHIFT_ARB_ROTATE_EN is defined, otherwise passes a through.
module shift_core
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] s;

    always_comb begin
        s = a;
        for (int k = 0; k < SHW; k++) begin
            if (shamt[k]) begin
                case (op)
                    OP_SLL: s = s << (1 << k);
                    OP_SRL: s = s >> (1 << k);
                    OP_SRA: s = $signed(s) >>> (1 << k);
`ifdef SHIFT_ARB_ROTATE_EN
                    OP_ROR: s = (s >> (1 << k)) | (s << (WIDTH - (1 << k)));
`else
                    OP_ROR: s = s;
`endif
                    default: s = s;
                endcase
            end
        end
        y = s;
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between an ALU and an LSU requester,
// with a single registered, ID-tagged response. Optional rotate via SHIFT_ARB_ROTATE_EN.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    shift_arbiter_if.slave  bus
);
    logic             last_grant;
    logic             grant_id;
    logic             can_accept;
    logic             fire;
    logic [WIDTH-1:0] sel_a;
    logic [SHW-1:0]   sel_shamt;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] core_y;
    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;

    always_comb begin
        grant_id = REQ_ALU;
        if (bus.req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (bus.req_valid[1]) begin
            grant_id = REQ_LSU;
        end
        can_accept = !resp_valid || bus.resp_ready;
        // reset gates ready so nothing looks accepted while the register is held clear
        fire = can_accept && !reset && (bus.req_valid != 2'b00);
        bus.req_ready = fire ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
        sel_a     = grant_id ? bus.req1_a     : bus.req0_a;
        sel_shamt = grant_id ? bus.req1_shamt : bus.req0_shamt;
        sel_op    = grant_id ? bus.req1_op    : bus.req0_op;
    end

    shift_core u_core (
        .a     (sel_a),
        .shamt (sel_shamt),
        .op    (sel_op),
        .y     (core_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= REQ_ALU;
            resp_data  <= '0;
            last_grant <= REQ_LSU;
        end else if (fire) begin
            resp_valid <= 1'b1;
            resp_id    <= grant_id;
            resp_data  <= core_y;
            last_grant <= grant_id;
        end else if (bus.resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid;
    assign bus.resp_id    = resp_id;
    assign bus.resp_data  = resp_data;
    assign bus.last_grant = last_grant;
endmodule
